// File: rtl/unsigned_approx_mult_pipe.sv
// unsigned_approx_mult_pipe
// Pipelined unsigned WxW multiplier on a valid/ready stream. The low L
// partial-product rows can be truncated below column KEEP_COL on a
// per-beat basis. The block reports the truncation error for each result
// and keeps a saturating count of approximate results that are delivered.
module unsigned_approx_mult_pipe #(
  parameter int W        = 8,
  parameter int L        = 2,
  parameter int KEEP_COL = 6,
  parameter int STAGES   = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_z,
  output logic [2*W-1:0]   out_err,
  output logic             out_approx,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] approx_cnt
);

  logic             adv;
  logic [2*W-1:0]   hi_c;
  logic [2*W-1:0]   keep_c;
  logic [2*W-1:0]   drop_c;
  logic [2*W-1:0]   a_c;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] mode_q;
  logic [2*W-1:0]    a_q [STAGES];
  logic [2*W-1:0]    d_q [STAGES];

  // The exact product is split into the approximate product plus the dropped
  // low-row bits. Both travel down the pipe, so the error needs no subtractor
  // and the exact result is recovered with a single add at the output.
  always_comb begin
    hi_c   = ((2*W)'(in_y) * (2*W)'(in_x >> L)) << L;
    keep_c = '0;
    drop_c = '0;
    for (int unsigned i = 0; i < L; i++) begin
      for (int unsigned j = 0; j < W; j++) begin
        if (in_x[i] & in_y[j]) begin
          if (int'(i + j) >= KEEP_COL)
            keep_c = keep_c + ((2*W)'(1) << (i + j));
          else
            drop_c = drop_c + ((2*W)'(1) << (i + j));
        end
      end
    end
    a_c = hi_c + keep_c;
  end

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Pipeline stages: the whole pipe shifts together on adv, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      mode_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        a_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else if (adv) begin
      v_q[0]    <= in_valid;
      mode_q[0] <= in_approx;
      a_q[0]    <= a_c;
      d_q[0]    <= drop_c;
      for (int unsigned i = 1; i < STAGES; i++) begin
        v_q[i]    <= v_q[i-1];
        mode_q[i] <= mode_q[i-1];
        a_q[i]    <= a_q[i-1];
        d_q[i]    <= d_q[i-1];
      end
    end
  end

  assign out_valid  = v_q[STAGES-1];
  assign out_approx = mode_q[STAGES-1];
  assign out_z      = mode_q[STAGES-1] ? a_q[STAGES-1] : a_q[STAGES-1] + d_q[STAGES-1];
  assign out_err    = mode_q[STAGES-1] ? d_q[STAGES-1] : '0;

  // Saturating count of delivered approximate results; clear wins over count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      approx_cnt <= '0;
    else if (cnt_clr)
      approx_cnt <= '0;
    else if (out_valid && out_ready && out_approx && (approx_cnt != '1))
      approx_cnt <= approx_cnt + 1'b1;
  end

endmodule

// File: tb/tb_unsigned_approx_mult_pipe.sv
module tb_unsigned_approx_mult_pipe;
  localparam int W        = 8;
  localparam int L        = 2;
  localparam int KEEP_COL = 6;
  localparam int STAGES   = 2;
  localparam int CNT_W    = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_y;
  logic             in_approx;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_z;
  logic [2*W-1:0]   out_err;
  logic             out_approx;
  logic             cnt_clr;
  logic [CNT_W-1:0] approx_cnt;

  unsigned_approx_mult_pipe #(
    .W(W), .L(L), .KEEP_COL(KEEP_COL), .STAGES(STAGES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_approx(in_approx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_err(out_err), .out_approx(out_approx),
    .cnt_clr(cnt_clr), .approx_cnt(approx_cnt)
  );

  typedef struct {
    logic [15:0] z;
    logic [15:0] e;
    logic        a;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: dropped value of row i is y masked to its columns below KEEP_COL-i.
  function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic a,
                                output logic [15:0] z, output logic [15:0] e);
    logic [15:0] p, d;
    int lim;
    p = 16'(x) * 16'(y);
    d = '0;
    for (int i = 0; i < L; i++) begin
      lim = KEEP_COL - i;
      if (lim < 0) lim = 0;
      if (x[i]) d = d + ((16'(y) & ((16'd1 << lim) - 16'd1)) << i);
    end
    z = a ? p - d : p;
    e = a ? d : 16'd0;
  endfunction

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic a,
                      input logic [15:0] ez, input logic [15:0] ee, input bit lat);
    exp_t it;
    int n;
    @(negedge clk);
    in_valid = 1; in_x = x; in_y = y; in_approx = a;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=in_ready0 required=in_ready1");
      in_valid = 0;
      return;
    end
    it.z = ez; it.e = ee; it.a = a; it.acc = lat ? cyc : -1;
    q.push_back(it);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic send_m(input logic [7:0] x, input logic [7:0] y, input logic a, input bit lat);
    logic [15:0] z, e;
    model(x, y, a, z, e);
    send(x, y, a, z, e, lat);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk); #3; n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
  endtask

  // Monitor: pops one expectation per delivered result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output actual=%0h required=none", out_z);
        end else begin
          e = q.pop_front();
          chk("out_z", 32'(out_z), 32'(e.z));
          chk("out_err", 32'(out_err), 32'(e.e));
          chk("out_approx", 32'(out_approx), 32'(e.a));
          if (e.acc >= 0) chk("latency", 32'(cyc - e.acc), 32'(STAGES));
        end
      end
    end
  end

  initial begin
    logic [15:0] held;
    int n;
    rst = 1; in_valid = 0; in_x = '0; in_y = '0; in_approx = 0;
    out_ready = 1; cnt_clr = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_z", 32'(out_z), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_out_approx", 32'(out_approx), 0);
    chk("rst_cnt", 32'(approx_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    repeat (3) @(negedge clk);
    rst = 0;

    // Directed corner operands
    send(8'hFF, 8'hFF, 1, 16'hFD84, 16'h007D, 1);
    send(8'hFF, 8'hFF, 0, 16'hFE01, 16'h0000, 1);
    send(8'h03, 8'h01, 1, 16'd0, 16'd3, 1);
    send(8'h04, 8'h05, 1, 16'd20, 16'd0, 1);
    drain();

    // Back-to-back alternating modes
    for (int i = 0; i < 10; i++)
      send_m(8'(8'h17 * i + 8'h3B), 8'(8'hA5 ^ (i * 8'h1F)), i[0], 1);
    drain();

    // Stall with pipe full
    send_m(8'hC7, 8'h9E, 1, 0);
    send_m(8'h5A, 8'hF3, 0, 0);
    @(negedge clk);
    out_ready = 0;
    #1;
    chk("stall_in_ready", 32'(in_ready), 0);
    chk("stall_valid", 32'(out_valid), 1);
    held = out_z;
    repeat (2) begin
      @(negedge clk); #1;
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_hold_z", 32'(out_z), 32'(held));
    end
    @(negedge clk);
    out_ready = 1;
    drain();

    // Reset with two beats in flight
    send_m(8'h81, 8'h42, 1, 0);
    send_m(8'h33, 8'hEE, 0, 0);
    @(negedge clk);
    rst = 1;
    q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_z", 32'(out_z), 0);
    chk("midrst_cnt", 32'(approx_cnt), 0);
    @(negedge clk);
    rst = 0;
    repeat (6) begin
      @(negedge clk); #1;
      chk("no_stale", 32'(out_valid), 0);
    end

    // Approximate-result counter
    for (int i = 0; i < 5; i++) send_m(8'(i + 1), 8'hF1, 1, 0);
    for (int i = 0; i < 3; i++) send_m(8'(i + 9), 8'h77, 0, 0);
    drain();
    @(negedge clk); #1;
    chk("cnt_five", 32'(approx_cnt), 5);
    @(negedge clk);
    out_ready = 0;
    send_m(8'hFF, 8'h3C, 1, 0);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!out_valid && n < 20);
    chk("clr_wait_valid", 32'(out_valid), 1);
    cnt_clr = 1;
    out_ready = 1;
    @(negedge clk);
    cnt_clr = 0;
    #1;
    chk("cnt_clr_priority", 32'(approx_cnt), 0);
    drain();
    for (int i = 0; i < 9; i++) send_m(8'(8'h20 + i), 8'h6D, 1, 0);
    drain();
    @(negedge clk); #1;
    chk("cnt_saturate", 32'(approx_cnt), 7);
    send_m(8'h99, 8'h99, 1, 0);
    drain();
    @(negedge clk); #1;
    chk("cnt_stay_sat", 32'(approx_cnt), 7);

    // Randomised operand sweep in both modes
    send_m(8'h00, 8'hFF, 1, 1);
    send_m(8'hFF, 8'h00, 0, 1);
    for (int i = 0; i < 1500; i++)
      send_m(8'($urandom), 8'($urandom), 1'($urandom), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
